pdp_rdma_split_seq: RTL

Split-width command sequencer in front of the PDP RDMA ingress. On op_en it walks the configured split/surface loop and emits one read-command descriptor per (split, surface) pair to the ingress over valid/ready. It throttles issue against a completion-credit count returned by egress and signals operation done to the register block.

---
 rtl/pdp_rdma_seq_pkg.sv | 53 +++++
 rtl/pdp_rdma_credit_cnt.sv | 50 +++++
 rtl/pdp_rdma_split_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pdp_rdma_seq_pkg.sv
// Shared types for the PDP RDMA split-width sequencer: FSM states, latched
// configuration, read-command descriptor and the per-split width rule.
package pdp_rdma_seq_pkg;

  localparam int IDX_W = 8;
  localparam int PW_W  = 10;
  localparam int CW_W  = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] split_idx;
    logic [CW_W-1:0]  x_start;
    logic [CW_W-1:0]  width;
    logic [IDX_W-1:0] surf_idx;
    logic             last;
  } seq_cmd_t;

  typedef struct packed {
    logic [IDX_W-1:0] split_num;
    logic [PW_W-1:0]  pw_first;
    logic [PW_W-1:0]  pw_mid;
    logic [PW_W-1:0]  pw_last;
    logic [CW_W-1:0]  cube_w;
    logic [IDX_W-1:0] surf_num_m1;
  } seq_cfg_t;

  // Unsplit operations use the full cube width; otherwise first/mid/last by position.
  function automatic logic [CW_W-1:0] split_width(input seq_cfg_t cfg, input logic [IDX_W-1:0] idx);
    logic [CW_W-1:0] w;
    if (cfg.split_num == 8'd0) begin
      w = cfg.cube_w;
    end else if (idx == 8'd0) begin
      w = {3'b000, cfg.pw_first};
    end else if (idx == cfg.split_num) begin
      w = {3'b000, cfg.pw_last};
    end else begin
      w = {3'b000, cfg.pw_mid};
    end
    return w;
  endfunction

  function automatic logic is_last(input seq_cfg_t cfg, input logic [IDX_W-1:0] split,
                                   input logic [IDX_W-1:0] surf);
    return (split == cfg.split_num) && (surf == cfg.surf_num_m1);
  endfunction

endpackage

// File: rtl/pdp_rdma_credit_cnt.sv
// Outstanding-command counter: +1 per issued command, -1 per completion,
// with full flag, next-cycle-empty flag and a sticky underflow error.
module pdp_rdma_credit_cnt #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty_next,
  output logic err
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Simultaneous issue and completion cancel; a completion at zero is an error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q == CNT_W'(0)) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_W'(0);
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign full       = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign empty_next = (cnt_d == CNT_W'(0));
  assign err        = err_q;

endmodule

// File: rtl/pdp_rdma_split_seq.sv
// PDP RDMA split-width command sequencer: walks split (outer) x surface (inner)
// and issues one descriptor per pair, throttled by completion credits.
module pdp_rdma_split_seq
  import pdp_rdma_seq_pkg::*;
#(
  parameter int ATOM_CH_LOG2    = 5,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 4
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        reg2dp_op_en,
  input  logic [7:0]  reg2dp_split_num,
  input  logic [9:0]  reg2dp_partial_width_in_first,
  input  logic [9:0]  reg2dp_partial_width_in_mid,
  input  logic [9:0]  reg2dp_partial_width_in_last,
  input  logic [12:0] reg2dp_cube_in_width,
  input  logic [12:0] reg2dp_cube_in_channel,
  output logic        seq2ig_cmd_valid,
  input  logic        seq2ig_cmd_ready,
  output logic [7:0]  seq2ig_cmd_split_idx,
  output logic [12:0] seq2ig_cmd_x_start,
  output logic [12:0] seq2ig_cmd_width,
  output logic [7:0]  seq2ig_cmd_surf_idx,
  output logic        seq2ig_cmd_last,
  input  logic        eg2seq_cmd_done,
  output logic        seq_busy,
  output logic        dp2reg_done,
  output logic        seq_err
);

  seq_state_e       state_q, state_d;
  seq_cfg_t         cfg_q, cfg_d, cfg_in;
  seq_cmd_t         cmd_q, cmd_d;
  logic             cnt_full, cnt_empty_next, hs;
  logic [IDX_W-1:0] nxt_split, nxt_surf;

  assign cfg_in.split_num   = reg2dp_split_num;
  assign cfg_in.pw_first    = reg2dp_partial_width_in_first;
  assign cfg_in.pw_mid      = reg2dp_partial_width_in_mid;
  assign cfg_in.pw_last     = reg2dp_partial_width_in_last;
  assign cfg_in.cube_w      = reg2dp_cube_in_width;
  assign cfg_in.surf_num_m1 = IDX_W'(reg2dp_cube_in_channel >> ATOM_CH_LOG2);

  // Issue is gated by the registered count, so a same-cycle completion frees nothing yet.
  assign seq2ig_cmd_valid = (state_q == ISSUE) && !cnt_full;
  assign hs               = seq2ig_cmd_valid && seq2ig_cmd_ready;

  pdp_rdma_credit_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_credit (
    .clk        (nvdla_core_clk),
    .rst        (nvdla_core_rst),
    .inc        (hs),
    .dec        (eg2seq_cmd_done),
    .full       (cnt_full),
    .empty_next (cnt_empty_next),
    .err        (seq_err)
  );

  // Next-state and next-descriptor logic; the descriptor register is the loop cursor.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    cmd_d     = cmd_q;
    nxt_split = cmd_q.split_idx + IDX_W'(1);
    nxt_surf  = cmd_q.surf_idx + IDX_W'(1);
    case (state_q)
      IDLE: begin
        if (reg2dp_op_en) begin
          cfg_d           = cfg_in;
          cmd_d.split_idx = IDX_W'(0);
          cmd_d.x_start   = CW_W'(0);
          cmd_d.width     = split_width(cfg_in, IDX_W'(0));
          cmd_d.surf_idx  = IDX_W'(0);
          cmd_d.last      = is_last(cfg_in, IDX_W'(0), IDX_W'(0));
          state_d         = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (hs && cmd_q.last) begin
          state_d = DRAIN;
        end else if (hs && (cmd_q.surf_idx == cfg_q.surf_num_m1)) begin
          cmd_d.split_idx = nxt_split;
          cmd_d.x_start   = cmd_q.x_start + cmd_q.width + CW_W'(1);
          cmd_d.width     = split_width(cfg_q, nxt_split);
          cmd_d.surf_idx  = IDX_W'(0);
          cmd_d.last      = is_last(cfg_q, nxt_split, IDX_W'(0));
        end else if (hs) begin
          cmd_d.surf_idx = nxt_surf;
          cmd_d.last     = is_last(cfg_q, cmd_q.split_idx, nxt_surf);
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (cnt_empty_next) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cmd_q   <= cmd_d;
    end
  end

  assign seq2ig_cmd_split_idx = cmd_q.split_idx;
  assign seq2ig_cmd_x_start   = cmd_q.x_start;
  assign seq2ig_cmd_width     = cmd_q.width;
  assign seq2ig_cmd_surf_idx  = cmd_q.surf_idx;
  assign seq2ig_cmd_last      = cmd_q.last;
  assign seq_busy             = (state_q != IDLE);
  assign dp2reg_done          = (state_q == DONE);

endmodule
